// File: rtl/sd_fifo_tx_filler_sc.sv
// sd_fifo_tx_filler_sc
//   TX-direction data master for the SD controller. Fetches a block from system
//   memory with classic single Wishbone read cycles (address = adr + offset) and
//   queues each word in a single-clock first-word-fall-through FIFO that the SD
//   data-serial side drains.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   m_wb_*          Wishbone read-only master (cyc == stb, classic cycles)
//   en              1 = fetch; 0 = abort outstanding read, flush FIFO, clear offset
//   adr             block base byte address, stable while en = 1
//   rd              SD-side pop request (ignored when empty or en = 0)
//   dat_o           FIFO head word, valid while empty = 0
//   empty/full      FIFO occupancy flags
//   level           FIFO occupancy, 0..FIFO_DEPTH
module sd_fifo_tx_filler_sc #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MEM_OFFSET = 4,
    parameter int unsigned OFFSET_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] m_wb_adr_o,
    output logic        m_wb_we_o,
    input  logic [31:0] m_wb_dat_i,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i,
    output logic [2:0]  m_wb_cti_o,
    output logic [1:0]  m_wb_bte_o,
    input  logic        en,
    input  logic [31:0] adr,
    input  logic        rd,
    output logic [31:0] dat_o,
    output logic        empty,
    output logic        full,
    output logic [6:0]  level
);

    localparam int unsigned          PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [6:0]           DEPTH_L = 7'(FIFO_DEPTH);
    localparam logic [OFFSET_W-1:0]  STEP_L  = OFFSET_W'(MEM_OFFSET);
    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [6:0]          count_q, count_d;
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [31:0]         mem_q [FIFO_DEPTH];
    logic                push, pop;

    // Only one read is ever outstanding and issue requires free space, so a push
    // can never land on a full FIFO.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        offset_d = offset_q;
        push     = 1'b0;
        if (!en) begin
            state_d  = IDLE;
            cyc_d    = 1'b0;
            offset_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q < DEPTH_L) begin
                        cyc_d   = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (m_wb_ack_i) begin
                        push     = 1'b1;
                        cyc_d    = 1'b0;
                        offset_d = offset_q + STEP_L;
                        state_d  = IDLE;
                    end
                end
            endcase
        end
    end

    assign pop = en && rd && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (!en) begin
            count_d = '0;
        end else begin
            count_d = count_q + 7'(push) - 7'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            offset_q <= '0;
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            offset_q <= offset_d;
            count_q  <= count_d;
            if (!en) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PTR_ONE;
                if (pop)  rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: contents are only observable through count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= m_wb_dat_i;
    end

    assign m_wb_adr_o = adr + 32'(offset_q);
    assign m_wb_we_o  = 1'b0;
    assign m_wb_cyc_o = cyc_q;
    assign m_wb_stb_o = cyc_q;
    assign m_wb_cti_o = '0;
    assign m_wb_bte_o = '0;

    assign dat_o = mem_q[rptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_L);
    assign level = count_q;

endmodule

// File: tb/tb_sd_fifo_tx_filler_sc.sv
module tb_sd_fifo_tx_filler_sc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_wb_adr_o;
    logic        m_wb_we_o;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic        m_wb_ack_i;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic        en;
    logic [31:0] adr;
    logic        rd;
    logic [31:0] dat_o;
    logic        empty;
    logic        full;
    logic [6:0]  level;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    logic [31:0] base;
    int unsigned exp_off;
    bit          auto_ack;
    bit          force_ack;

    sd_fifo_tx_filler_sc #(
        .FIFO_DEPTH (8),
        .MEM_OFFSET (4),
        .OFFSET_W   (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_dat_i (m_wb_dat_i),
        .m_wb_cyc_o (m_wb_cyc_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_ack_i (m_wb_ack_i),
        .m_wb_cti_o (m_wb_cti_o),
        .m_wb_bte_o (m_wb_bte_o),
        .en         (en),
        .adr        (adr),
        .rd         (rd),
        .dat_o      (dat_o),
        .empty      (empty),
        .full       (full),
        .level      (level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model: word content is a fixed function of its byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Advance to the next falling edge and play the memory side: ack the
    // current cycle (auto mode), and record the word the bench expects to be
    // queued from its own address model.
    task automatic step();
        @(negedge clk);
        m_wb_ack_i = force_ack | (auto_ack & m_wb_cyc_o);
        m_wb_dat_i = mem_word(m_wb_adr_o);
        if (m_wb_ack_i && m_wb_cyc_o && full && en && !rst) begin
            failures++;
            $display("FAIL overflow: ack into full FIFO, level=%0d", level);
        end
        if (auto_ack && m_wb_cyc_o && en && !rst) begin
            sb.push_back(mem_word(base + exp_off));
            exp_off = (exp_off + 4) % 512;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; rd = 1'b0; force_ack = 1'b1; auto_ack = 1'b0;
        adr = 32'h0000_1000; base = adr; exp_off = 0;
        m_wb_ack_i = 1'b0; m_wb_dat_i = '0;
        step();
        step();
        checks++;
        if (m_wb_cyc_o !== 1'b0 || m_wb_stb_o !== 1'b0 || m_wb_we_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus: cyc=%b stb=%b we=%b required 0 0 0", m_wb_cyc_o, m_wb_stb_o, m_wb_we_o);
        end
        checks++;
        if (m_wb_cti_o !== 3'b000 || m_wb_bte_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_cti_bte: cti=%b bte=%b required 000 00", m_wb_cti_o, m_wb_bte_o);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || level !== 7'd0) begin
            failures++;
            $display("FAIL reset_fifo: empty=%b full=%b level=%0d required 1 0 0", empty, full, level);
        end
        checks++;
        if (m_wb_adr_o !== 32'h0000_1000) begin
            failures++;
            $display("FAIL reset_offset: adr_o=%h required 00001000", m_wb_adr_o);
        end
        rst = 1'b0; en = 1'b0; force_ack = 1'b0;
        step();
    endtask

    task automatic test_zero_wait_fill();
        en = 1'b1; auto_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (m_wb_cyc_o !== 1'b1 || m_wb_stb_o !== 1'b1 || m_wb_adr_o !== 32'h1000 + 32'(4 * i)) begin
                failures++;
                $display("FAIL fill_issue[%0d]: cyc=%b stb=%b adr=%h required 1 1 %h",
                         i, m_wb_cyc_o, m_wb_stb_o, m_wb_adr_o, 32'h1000 + 32'(4 * i));
            end
            step();
            checks++;
            if (m_wb_cyc_o !== 1'b0 || level !== 7'(i + 1)) begin
                failures++;
                $display("FAIL fill_ack[%0d]: cyc=%b level=%0d required 0 %0d", i, m_wb_cyc_o, level, i + 1);
            end
        end
        checks++;
        if (full !== 1'b1 || level !== 7'd8) begin
            failures++;
            $display("FAIL fill_full: full=%b level=%0d required 1 8", full, level);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (m_wb_cyc_o !== 1'b0) begin
                failures++;
                $display("FAIL fill_hold[%0d]: cyc=%b required 0", i, m_wb_cyc_o);
            end
        end
    endtask

    task automatic test_drain_refill();
        logic [31:0] w;
        checks++;
        w = sb.pop_front();
        if (dat_o !== w) begin
            failures++;
            $display("FAIL drain_head: dat_o=%h required %h", dat_o, w);
        end
        rd = 1'b1;
        step();
        rd = 1'b0;
        checks++;
        if (level !== 7'd7 || m_wb_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_pop: level=%0d cyc=%b required 7 0", level, m_wb_cyc_o);
        end
        step();
        checks++;
        if (m_wb_cyc_o !== 1'b1 || m_wb_adr_o !== 32'h0000_1020) begin
            failures++;
            $display("FAIL refill_issue: cyc=%b adr=%h required 1 00001020", m_wb_cyc_o, m_wb_adr_o);
        end
        step();
        checks++;
        if (level !== 7'd8 || full !== 1'b1) begin
            failures++;
            $display("FAIL refill_full: level=%0d full=%b required 8 1", level, full);
        end
        for (int k = 0; k < 8; k++) begin
            rd = 1'b0;
            if (!empty) begin
                checks++;
                w = sb.pop_front();
                if (dat_o !== w) begin
                    failures++;
                    $display("FAIL drain_order[%0d]: dat_o=%h required %h", k + 1, dat_o, w);
                end
                rd = 1'b1;
            end
            step();
        end
        rd = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] w;
        bit          found;
        int          npop;
        en = 1'b0; rd = 1'b0;
        step();
        sb.delete();
        exp_off = 0;
        checks++;
        if (level !== 7'd0 || empty !== 1'b1 || m_wb_cyc_o !== 1'b0 || m_wb_adr_o !== 32'h0000_1000) begin
            failures++;
            $display("FAIL flush: level=%0d empty=%b cyc=%b adr=%h required 0 1 0 00001000",
                     level, empty, m_wb_cyc_o, m_wb_adr_o);
        end
        en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (m_wb_cyc_o && m_wb_ack_i && level == 7'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL simul_setup: level=3 with ack not reached, level=%0d required 3", level);
        end
        checks++;
        w = sb.pop_front();
        if (dat_o !== w) begin
            failures++;
            $display("FAIL simul_head: dat_o=%h required %h", dat_o, w);
        end
        rd = 1'b1;
        step();
        rd = 1'b0;
        checks++;
        if (level !== 7'd3) begin
            failures++;
            $display("FAIL simul_level: level=%0d required 3", level);
        end
        auto_ack = 1'b0;
        npop = 0;
        for (int k = 0; k < 20; k++) begin
            if (empty) break;
            checks++;
            w = sb.pop_front();
            if (dat_o !== w) begin
                failures++;
                $display("FAIL simul_order[%0d]: dat_o=%h required %h", k, dat_o, w);
            end
            rd = 1'b1;
            npop++;
            step();
        end
        rd = 1'b0;
        checks++;
        if (npop != 3 || sb.size() != 0) begin
            failures++;
            $display("FAIL simul_count: pops=%0d leftover=%0d required 3 0", npop, sb.size());
        end
    endtask

    task automatic test_abort();
        logic [31:0] w;
        checks++;
        if (m_wb_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: cyc=%b required 1", m_wb_cyc_o);
        end
        en = 1'b0;
        step();
        sb.delete();
        exp_off = 0;
        checks++;
        if (m_wb_cyc_o !== 1'b0 || m_wb_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_cyc: cyc=%b stb=%b required 0 0", m_wb_cyc_o, m_wb_stb_o);
        end
        step();
        force_ack = 1'b1;
        step();
        step();
        force_ack = 1'b0;
        step();
        checks++;
        if (level !== 7'd0 || empty !== 1'b1 || m_wb_adr_o !== base) begin
            failures++;
            $display("FAIL abort_late_ack: level=%0d empty=%b adr=%h required 0 1 %h",
                     level, empty, m_wb_adr_o, base);
        end
        en = 1'b1; auto_ack = 1'b1;
        step();
        checks++;
        if (m_wb_cyc_o !== 1'b1 || m_wb_adr_o !== base) begin
            failures++;
            $display("FAIL reenable_adr: cyc=%b adr=%h required 1 %h", m_wb_cyc_o, m_wb_adr_o, base);
        end
        step();
        checks++;
        w = sb.pop_front();
        if (level !== 7'd1 || dat_o !== w) begin
            failures++;
            $display("FAIL reenable_data: level=%0d dat_o=%h required 1 %h", level, dat_o, w);
        end
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic test_wrap_underflow();
        logic [31:0] w;
        int          n;
        en = 1'b0; rd = 1'b0; auto_ack = 1'b1;
        step();
        sb.delete();
        exp_off = 0;
        adr = 32'h8000_0000; base = adr;
        en = 1'b1;
        n = 0;
        for (int k = 0; k < 1000 && n < 130; k++) begin
            step();
            rd = 1'b0;
            if (m_wb_cyc_o && m_wb_ack_i) begin
                checks++;
                if (m_wb_adr_o !== base + 32'((n * 4) % 512)) begin
                    failures++;
                    $display("FAIL wrap_adr[%0d]: adr=%h required %h", n, m_wb_adr_o, base + 32'((n * 4) % 512));
                end
                if (n == 128) begin
                    checks++;
                    if (m_wb_adr_o !== 32'h8000_0000) begin
                        failures++;
                        $display("FAIL wrap_return: adr=%h required 80000000", m_wb_adr_o);
                    end
                end
                n++;
            end
            if (!empty) begin
                checks++;
                w = sb.pop_front();
                if (dat_o !== w) begin
                    failures++;
                    $display("FAIL wrap_data[%0d]: dat_o=%h required %h", n, dat_o, w);
                end
                rd = 1'b1;
            end
        end
        checks++;
        if (n != 130) begin
            failures++;
            $display("FAIL wrap_count: reads=%0d required 130", n);
        end
        auto_ack = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            rd = 1'b0;
            if (!empty) begin
                checks++;
                w = sb.pop_front();
                if (dat_o !== w) begin
                    failures++;
                    $display("FAIL wrap_drain[%0d]: dat_o=%h required %h", k, dat_o, w);
                end
                rd = 1'b1;
            end
        end
        step();
        rd = 1'b0;
        checks++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL wrap_drained: empty=%b leftover=%0d required 1 0", empty, sb.size());
        end
        rd = 1'b1;
        step();
        step();
        rd = 1'b0;
        checks++;
        if (level !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL underflow: level=%0d empty=%b full=%b required 0 1 0", level, empty, full);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_fill();
        test_drain_refill();
        test_simultaneous();
        test_abort();
        test_wrap_underflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
